// File: rtl/wb_trace_fifo.sv
// Writeback trace capture FIFO: first-word fall-through, drops captures when full and flags it.
// Optional TRACE_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   wb_pc,
    input  logic [3:0]    wb_rf_wen,
    input  logic [4:0]    wb_rf_wnum,
    input  logic [31:0]   wb_rf_wdata,
    output logic          tr_valid,
    input  logic          tr_ready,
    output logic [31:0]   tr_pc,
    output logic [4:0]    tr_wnum,
    output logic [3:0]    tr_wen,
    output logic [31:0]   tr_wdata,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_overflow
`ifdef TRACE_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int          EW       = 73;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, full, wr_en, drop;

    assign push  = (wb_rf_wen != 4'b0) && (wb_rf_wnum != 5'd0);
    assign pop   = tr_valid && tr_ready;
    assign full  = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) wptr_d = wptr_q + AW'(1);
        if (pop)   rptr_d = rptr_q + AW'(1);
        if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !wr_en) count_d = count_q - (AW+1)'(1);
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {wb_pc, wb_rf_wnum, wb_rf_wen, wb_rf_wdata};
    end

    assign {tr_pc, tr_wnum, tr_wen, tr_wdata} = mem_q[rptr_q];
    assign tr_valid = (count_q != '0);
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A drop coinciding with a clear must still be counted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_overflow)                     drop_cnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: directed scenarios plus randomized traffic
// against a queue-based occupancy model.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [3:0]  wb_rf_wen = '0;
    logic [4:0]  wb_rf_wnum = '0;
    logic [31:0] wb_rf_wdata = '0;
    logic        tr_valid;
    logic        tr_ready = 1'b0;
    logic [31:0] tr_pc;
    logic [4:0]  tr_wnum;
    logic [3:0]  tr_wen;
    logic [31:0] tr_wdata;
    logic [AW:0] count;
    logic        overflow;
    logic        clr_overflow = 1'b0;
`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen), .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata),
        .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_pc(tr_pc), .tr_wnum(tr_wnum), .tr_wen(tr_wen), .tr_wdata(tr_wdata),
        .count(count), .overflow(overflow), .clr_overflow(clr_overflow)
`ifdef TRACE_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue of packed entries plus occupancy.
    logic [72:0] exp_q[$];
    int          model_count = 0;
    logic        ovf_m = 1'b0;
    int          drop_m = 0;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge using the inputs the DUT sees.
    always @(posedge clk) begin
        if (resetn) begin
            bit p_pop, p_push, p_drop;
            p_pop  = (model_count > 0) && tr_ready;
            p_push = (wb_rf_wen != 0) && (wb_rf_wnum != 0);
            p_drop = p_push && (model_count == DEPTH) && !p_pop;
            if (p_push && !p_drop) begin
                exp_q.push_back({wb_pc, wb_rf_wnum, wb_rf_wen, wb_rf_wdata});
                model_count++;
            end
            if (p_pop) model_count--;
            if (p_drop) ovf_m = 1'b1;
            else if (clr_overflow) ovf_m = 1'b0;
            if (clr_overflow) drop_m = p_drop ? 1 : 0;
            else if (p_drop && drop_m < 16'hFFFF) drop_m++;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        chk("count", 73'(count), 73'(model_count));
        chk("tr_valid", 73'(tr_valid), 73'(model_count != 0));
        chk("overflow", 73'(overflow), 73'(ovf_m));
`ifdef TRACE_DROP_CNT_EN
        chk("drop_cnt", 73'(drop_cnt), 73'(drop_m));
`endif
        if (tr_valid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", 73'(1), 73'(0));
            end else if (tr_ready) begin
                logic [72:0] e;
                e = exp_q.pop_front();
                chk("pop_entry", {tr_pc, tr_wnum, tr_wen, tr_wdata}, e);
                $display("pop pc=%h wnum=%0d wen=%h wdata=%h", tr_pc, tr_wnum, tr_wen, tr_wdata);
            end else begin
                chk("head_hold", {tr_pc, tr_wnum, tr_wen, tr_wdata}, exp_q[0]);
            end
        end
    end

    task automatic drive(input logic [3:0] wen, input logic [4:0] wnum, input logic [31:0] pc,
                         input logic [31:0] wdata, input logic rdy, input logic clr);
        wb_rf_wen = wen; wb_rf_wnum = wnum; wb_pc = pc; wb_rf_wdata = wdata;
        tr_ready = rdy; clr_overflow = clr;
        @(posedge clk); #1;
    endtask

    task automatic push_rand(input logic rdy, input logic clr);
        drive(4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)), $urandom, $urandom, rdy, clr);
    endtask

    task automatic idle(input logic rdy);
        drive(4'h0, 5'd0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_count = 0;
        ovf_m = 1'b0;
        drop_m = 0;
    endtask

    initial begin
        int max_cnt;
        #1;
        chk("reset_count", 73'(count), 73'(0));
        chk("reset_valid", 73'(tr_valid), 73'(0));
        chk("reset_overflow", 73'(overflow), 73'(0));
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single capture visible the cycle after its edge.
        drive(4'hF, 5'd5, 32'hBFC0_0000, 32'h1234, 1'b0, 1'b0);
        chk("first_valid", 73'(tr_valid), 73'(1));
        chk("first_pc", 73'(tr_pc), 73'(32'hBFC0_0000));
        chk("first_wnum", 73'(tr_wnum), 73'(5));
        chk("first_wdata", 73'(tr_wdata), 73'(32'h1234));
        chk("first_count", 73'(count), 73'(1));
        idle(1'b1);
        chk("first_drained", 73'(count), 73'(0));

        // Non-capturing writebacks: wnum=0 or wen=0.
        drive(4'hF, 5'd0, 32'h100, 32'h1, 1'b0, 1'b0);
        drive(4'h0, 5'd3, 32'h104, 32'h2, 1'b0, 1'b0);
        chk("nocap_count", 73'(count), 73'(0));
        chk("nocap_valid", 73'(tr_valid), 73'(0));

        // Fill, overflow by 3, then clear.
        for (int i = 0; i < DEPTH + 3; i++) push_rand(1'b0, 1'b0);
        chk("full_count", 73'(count), 73'(DEPTH));
        chk("full_overflow", 73'(overflow), 73'(1));
`ifdef TRACE_DROP_CNT_EN
        chk("full_drop_cnt", 73'(drop_cnt), 73'(3));
`endif
        idle(1'b0);
        drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_overflow", 73'(overflow), 73'(0));

        // Push and pop together while full.
        push_rand(1'b1, 1'b0);
        chk("fullpp_count", 73'(count), 73'(DEPTH));
        chk("fullpp_overflow", 73'(overflow), 73'(0));

        // Drop in the same cycle as clear leaves overflow set.
        push_rand(1'b0, 1'b1);
        chk("clrdrop_overflow", 73'(overflow), 73'(1));
`ifdef TRACE_DROP_CNT_EN
        chk("clrdrop_cnt", 73'(drop_cnt), 73'(1));
`endif
        drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        chk("drain_count", 73'(count), 73'(0));

        // Streaming across pointer wrap.
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            push_rand(1'b1, 1'b0);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        chk("stream_max_count", 73'(max_cnt), 73'(1));
        idle(1'b1);

        // Asynchronous reset mid-cycle with 7 entries held.
        for (int i = 0; i < 7; i++) push_rand(1'b0, 1'b0);
        chk("pre_reset_count", 73'(count), 73'(7));
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_reset_count", 73'(count), 73'(0));
        chk("async_reset_valid", 73'(tr_valid), 73'(0));
        chk("async_reset_overflow", 73'(overflow), 73'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        push_rand(1'b0, 1'b0);
        chk("post_reset_push", 73'(count), 73'(1));

        // Randomized traffic: slow consumer first to reach full, then fast.
        for (int i = 0; i < 2000; i++) begin
            int rp;
            logic rdy, clr;
            rp  = (i < 1000) ? 30 : 80;
            rdy = ($urandom_range(0, 99) < rp);
            clr = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0)
                drive(4'($urandom_range(0, 1) * $urandom_range(0, 15)), 5'($urandom_range(0, 1)),
                      $urandom, $urandom, rdy, clr);
            else
                push_rand(rdy, clr);
        end
        for (int i = 0; i < DEPTH + 4; i++) idle(1'b1);
        chk("final_scoreboard_empty", 73'(exp_q.size()), 73'(0));
        chk("final_count", 73'(count), 73'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
